// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) constants, FSM state type and the encode function
// used by the transmit path.
package ham_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    // Bit indices of the parity positions 1, 2 and 4 within the codeword
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int P4_IDX = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ham_state_t;

    function automatic logic [CW_W-1:0] ham_encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        cw         = '0;
        cw[2]      = d[0];
        cw[4]      = d[1];
        cw[5]      = d[2];
        cw[6]      = d[3];
        cw[P1_IDX] = d[0] ^ d[1] ^ d[3];
        cw[P2_IDX] = d[0] ^ d[2] ^ d[3];
        cw[P4_IDX] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

endpackage

// File: rtl/ham_serializer.sv
// LSB-first serializer for one 7-bit codeword; each bit is held
// CLKS_PER_BIT cycles, with start/end-of-frame flags.
module ham_serializer
    import ham_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CW_W-1:0] load_data,
    output logic            busy,
    output logic            tx_bit,
    output logic            tx_valid,
    output logic            tx_sof,
    output logic            tx_eof
);

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDX_LAST = 3'(CW_W - 1);

    ham_state_t      state_reg, state_next;
    logic [7:0]      cnt_reg, cnt_next;
    logic [2:0]      idx_reg, idx_next;
    logic [CW_W-1:0] sr_reg, sr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            sr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            sr_reg    <= sr_next;
        end
    end

    // Outputs decode straight from the registers so an asynchronous reset
    // clears them in the same cycle it is asserted.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        sr_next    = sr_reg;
        busy       = 1'b0;
        tx_bit     = 1'b0;
        tx_valid   = 1'b0;
        tx_sof     = 1'b0;
        tx_eof     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    state_next = ST_SHIFT;
                    cnt_next   = '0;
                    idx_next   = '0;
                    sr_next    = load_data;
                end
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_bit   = sr_reg[idx_reg];
                tx_sof   = (idx_reg == 3'd0);
                tx_eof   = (idx_reg == IDX_LAST);
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) encoder with single-bit error injection, registered
// codeword output and a serial transmit port.
module ham_encoder_tx
    import ham_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        inj_pos,
    output logic [CW_W-1:0]   cw_out,
    output logic              cw_valid,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_sof,
    output logic              tx_eof
);

    logic            busy;
    logic            accept;
    logic [CW_W-1:0] inj_mask;
    logic [CW_W-1:0] cw_next;
    logic [CW_W-1:0] cw_out_reg;
    logic            cw_valid_reg;

    assign in_ready = ~busy;
    assign accept   = in_valid & in_ready;

    // inj_pos counts Hamming positions from 1, so position gi+1 maps to bit gi
    generate
        for (genvar gi = 0; gi < CW_W; gi++) begin : g_inj
            assign inj_mask[gi] = (inj_pos == 3'(gi + 1));
        end
    endgenerate

    assign cw_next = ham_encode(in_data) ^ inj_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_out_reg   <= '0;
            cw_valid_reg <= 1'b0;
        end else begin
            cw_valid_reg <= accept;
            if (accept) begin
                cw_out_reg <= cw_next;
            end
        end
    end

    assign cw_out   = cw_out_reg;
    assign cw_valid = cw_valid_reg;

    ham_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (cw_next),
        .busy      (busy),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .tx_sof    (tx_sof),
        .tx_eof    (tx_eof)
    );

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Directed bench for ham_encoder_tx: one instance at CLKS_PER_BIT=1 and
// one at CLKS_PER_BIT=3 for back-to-back framing.
module tb_ham_encoder_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, in_valid1, in_ready1, cw_valid1, tx_bit1, tx_valid1, tx_sof1, tx_eof1;
    logic [3:0] in_data1;
    logic [2:0] inj_pos1;
    logic [6:0] cw_out1;

    logic       rst3, in_valid3, in_ready3, cw_valid3, tx_bit3, tx_valid3, tx_sof3, tx_eof3;
    logic [3:0] in_data3;
    logic [2:0] inj_pos3;
    logic [6:0] cw_out3;

    ham_encoder_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .inj_pos(inj_pos1), .cw_out(cw_out1), .cw_valid(cw_valid1),
        .tx_bit(tx_bit1), .tx_valid(tx_valid1), .tx_sof(tx_sof1), .tx_eof(tx_eof1)
    );

    ham_encoder_tx #(.CLKS_PER_BIT(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .inj_pos(inj_pos3), .cw_out(cw_out3), .cw_valid(cw_valid3),
        .tx_bit(tx_bit3), .tx_valid(tx_valid3), .tx_sof(tx_sof3), .tx_eof(tx_eof3)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] data;
        logic [2:0] inj;
        logic [6:0] cw;
        logic [2:0] syn;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Receiver-side parity check: a nonzero result names the flipped position
    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {c[3] ^ c[4] ^ c[5] ^ c[6],
                c[1] ^ c[2] ^ c[5] ^ c[6],
                c[0] ^ c[2] ^ c[4] ^ c[6]};
    endfunction

    task automatic reset_outputs1(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready1), 32'd1);
        chk({tag, "_cw_out"},   32'(cw_out1),   32'd0);
        chk({tag, "_cw_valid"}, 32'(cw_valid1), 32'd0);
        chk({tag, "_tx_bit"},   32'(tx_bit1),   32'd0);
        chk({tag, "_tx_valid"}, 32'(tx_valid1), 32'd0);
        chk({tag, "_tx_sof"},   32'(tx_sof1),   32'd0);
        chk({tag, "_tx_eof"},   32'(tx_eof1),   32'd0);
    endtask

    // Accept one nibble on dut1 and follow its whole frame; in_valid stays
    // high with junk data during the frame, which must be ignored.
    task automatic frame1(input logic [3:0] d, input logic [2:0] inj, input logic [6:0] exp_cw);
        in_valid1 = 1'b1;
        in_data1  = d;
        inj_pos1  = inj;
        @(posedge clk); #1;
        chk("acc_cw_out",   32'(cw_out1),   32'(exp_cw));
        chk("acc_cw_valid", 32'(cw_valid1), 32'd1);
        chk("acc_in_ready", 32'(in_ready1), 32'd0);
        in_data1 = ~d;
        inj_pos1 = 3'd3;
        for (int k = 0; k < 7; k++) begin
            chk("bit_tx_valid", 32'(tx_valid1), 32'd1);
            chk("bit_tx_bit",   32'(tx_bit1),   32'(exp_cw[k]));
            chk("bit_tx_sof",   32'(tx_sof1),   32'(k == 0));
            chk("bit_tx_eof",   32'(tx_eof1),   32'(k == 6));
            if (k > 0) chk("bit_cw_valid", 32'(cw_valid1), 32'd0);
            if (k == 5) in_valid1 = 1'b0;
            @(posedge clk); #1;
        end
        chk("end_tx_valid", 32'(tx_valid1), 32'd0);
        chk("end_tx_bit",   32'(tx_bit1),   32'd0);
        chk("end_in_ready", 32'(in_ready1), 32'd1);
        chk("end_cw_hold",  32'(cw_out1),   32'(exp_cw));
    endtask

    initial begin
        logic [6:0] c;
        logic [6:0] e3;
        int         w;

        rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0; inj_pos1 = '0;
        rst3 = 1'b1; in_valid3 = 1'b0; in_data3 = '0; inj_pos3 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_outputs1("rst_init");
        chk("rst_init_in_ready3", 32'(in_ready3), 32'd1);
        chk("rst_init_tx_valid3", 32'(tx_valid3), 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{4'b1101, 3'd0, 7'b1100110, 3'd0};
        vecs[1] = '{4'b1101, 3'd5, 7'b1110110, 3'd5};
        vecs[2] = '{4'b0000, 3'd0, 7'b0000000, 3'd0};
        vecs[3] = '{4'b1111, 3'd0, 7'b1111111, 3'd0};
        vecs[4] = '{4'b0110, 3'd0, 7'b0110011, 3'd0};
        vecs[5] = '{4'b1111, 3'd7, 7'b0111111, 3'd7};
        vecs[6] = '{4'b0000, 3'd1, 7'b0000001, 3'd1};

        for (int i = 0; i < 7; i++) begin
            frame1(vecs[i].data, vecs[i].inj, vecs[i].cw);
            chk("vec_syndrome", 32'(syndrome(cw_out1)), 32'(vecs[i].syn));
            $display("vec %0d data=%b inj=%0d cw_out=%b exp=%b", i, vecs[i].data,
                     vecs[i].inj, cw_out1, vecs[i].cw);
        end

        // Every clean codeword: data bits in place and zero syndrome
        for (int d = 0; d < 16; d++) begin
            in_valid1 = 1'b1;
            in_data1  = 4'(d);
            inj_pos1  = 3'd0;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            c = cw_out1;
            chk("sweep_data", 32'({c[6], c[5], c[4], c[2]}), 32'(d));
            chk("sweep_syndrome", 32'(syndrome(c)), 32'd0);
            $display("sweep data=%b cw_out=%b", 4'(d), c);
            repeat (7) @(posedge clk);
            #1;
            chk("sweep_in_ready", 32'(in_ready1), 32'd1);
        end

        // Reset in the middle of a frame, at the 4th bit
        in_valid1 = 1'b1;
        in_data1  = 4'b1101;
        inj_pos1  = 3'd0;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_tx_valid", 32'(tx_valid1), 32'd1);
        chk("mid_tx_bit4",  32'(tx_bit1),   32'd0);
        rst1 = 1'b1;
        #1;
        reset_outputs1("rst_mid");
        @(posedge clk); #1;
        rst1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("post_rst_tx_valid", 32'(tx_valid1), 32'd0);
            @(posedge clk); #1;
        end
        frame1(4'b0110, 3'd0, 7'b0110011);
        $display("reset-abort frame: restarted cw_out=%b", cw_out1);

        // CLKS_PER_BIT=3 with in_valid held high: back-to-back frames
        e3        = 7'b1100110;
        in_data3  = 4'b1101;
        inj_pos3  = 3'd0;
        in_valid3 = 1'b1;
        w = 0;
        while (tx_valid3 !== 1'b1 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("cpb3_start", 32'(tx_valid3), 32'd1);
        for (int f = 0; f < 3; f++) begin
            for (int cy = 0; cy < 21; cy++) begin
                chk("cpb3_tx_valid", 32'(tx_valid3), 32'd1);
                chk("cpb3_in_ready", 32'(in_ready3), 32'd0);
                chk("cpb3_tx_bit",   32'(tx_bit3),   32'(e3[cy / 3]));
                chk("cpb3_tx_sof",   32'(tx_sof3),   32'(cy < 3));
                chk("cpb3_tx_eof",   32'(tx_eof3),   32'(cy >= 18));
                @(posedge clk); #1;
            end
            chk("cpb3_gap_tx_valid", 32'(tx_valid3), 32'd0);
            chk("cpb3_gap_in_ready", 32'(in_ready3), 32'd1);
            $display("cpb3 frame %0d cw_out=%b", f, cw_out3);
            @(posedge clk); #1;
        end
        in_valid3 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
